// File: rtl/iir_tdm_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade: tap order,
// FSM states and fixed-point round/saturate helpers.
package iir_tdm_pkg;

  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned TAP_B0   = 0;
  localparam int unsigned TAP_B1   = 1;
  localparam int unsigned TAP_B2   = 2;
  localparam int unsigned TAP_A1   = 3;
  localparam int unsigned TAP_A2   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Three guard bits cover the sum of five full-precision products.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 3;
  endfunction

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int unsigned frac);
    return (v + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic is_clip(input logic signed [63:0] v, input int unsigned w);
    return (v > sat_max(w)) || (v < (-sat_max(w) - 64'sd1));
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    if (v > sat_max(w))
      return sat_max(w);
    else if (v < (-sat_max(w) - 64'sd1))
      return -sat_max(w) - 64'sd1;
    else
      return v;
  endfunction

endpackage

// File: rtl/iir_tdm_mac.sv
// Shared multiply-accumulate: one signed product per enabled edge, with
// combinational round-half-up and saturation of the accumulator.
module iir_tdm_mac
  import iir_tdm_pkg::*;
#(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned COEF_FRAC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] y_c,
  output logic                     sat_c
);

  localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W);
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       rnd;

  assign prod     = PROD_W'(data) * PROD_W'(coef);
  assign prod_ext = ACC_W'(prod);
  assign acc_base = load ? '0 : acc;

  // load starts a fresh section so no separate clear cycle is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc <= '0;
    else if (en)
      acc <= sub ? (acc_base - prod_ext) : (acc_base + prod_ext);
  end

  assign rnd   = round_half_up(64'(acc), COEF_FRAC);
  assign y_c   = DATA_W'(saturate(rnd, DATA_W));
  assign sat_c = is_clip(rnd, DATA_W);

endmodule

// File: rtl/iir_cascade_tdm.sv
// Cascade of NUM_SEC Direct Form I biquads sharing one MAC; six edges per
// section (five taps plus write-back), programmable coefficients and bypass.
module iir_cascade_tdm
  import iir_tdm_pkg::*;
#(
  parameter int unsigned DIN_W     = 12,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned IN_SHIFT  = 6,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned COEF_FRAC = 16,
  parameter int unsigned NUM_SEC   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIN_W-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     dout_prevalid,
  input  logic                     coef_we,
  input  logic [7:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic [NUM_SEC-1:0]       bypass_mask,
  input  logic                     state_clr,
  output logic                     sat_flag
);

  localparam int unsigned NUM_COEF = NUM_SEC * NUM_TAPS;
  localparam int unsigned SEC_W    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int unsigned CIDX_W   = $clog2(NUM_COEF);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(64'd1 << COEF_FRAC);

  state_t                     state;
  logic [SEC_W-1:0]           sec;
  logic [2:0]                 tap;
  logic signed [DATA_W-1:0]   cur_x;
  logic signed [COEF_W-1:0]   coef [NUM_COEF];
  logic signed [DATA_W-1:0]   x1 [NUM_SEC];
  logic signed [DATA_W-1:0]   x2 [NUM_SEC];
  logic signed [DATA_W-1:0]   y1 [NUM_SEC];
  logic signed [DATA_W-1:0]   y2 [NUM_SEC];

  logic [CIDX_W-1:0]          cidx;
  logic signed [DATA_W-1:0]   mac_data;
  logic                       mac_sub;
  logic signed [DATA_W-1:0]   mac_y_c;
  logic                       mac_sat_c;
  logic signed [DATA_W-1:0]   y_wb;
  logic                       accept;
  logic                       coef_wr_ok;
  logic                       bypass_cur;

  assign accept     = din_valid && din_ready && !state_clr;
  assign coef_wr_ok = coef_we && din_ready && (coef_addr < 8'(NUM_COEF));
  assign bypass_cur = bypass_mask[sec];
  assign y_wb       = bypass_cur ? cur_x : mac_y_c;

  // Operand select for the current tap of the current section
  always_comb begin
    cidx     = CIDX_W'(32'(sec) * NUM_TAPS + 32'(tap));
    mac_data = cur_x;
    mac_sub  = 1'b0;
    case (tap)
      3'(TAP_B1): mac_data = x1[sec];
      3'(TAP_B2): mac_data = x2[sec];
      3'(TAP_A1): begin
        mac_data = y1[sec];
        mac_sub  = 1'b1;
      end
      3'(TAP_A2): begin
        mac_data = y2[sec];
        mac_sub  = 1'b1;
      end
      default: mac_data = cur_x;
    endcase
  end

  iir_tdm_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_MAC),
    .load (tap == 3'(TAP_B0)),
    .sub  (mac_sub),
    .data (mac_data),
    .coef (coef[cidx]),
    .y_c  (mac_y_c),
    .sat_c(mac_sat_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      sec           <= '0;
      tap           <= '0;
      cur_x         <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      dout_prevalid <= 1'b0;
      din_ready     <= 1'b1;
      sat_flag      <= 1'b0;
      for (int unsigned k = 0; k < NUM_SEC; k++) begin
        x1[k] <= '0;
        x2[k] <= '0;
        y1[k] <= '0;
        y2[k] <= '0;
      end
      for (int unsigned i = 0; i < NUM_COEF; i++)
        coef[i] <= ((i % NUM_TAPS) == TAP_B0) ? COEF_ONE : '0;
    end else begin
      dout_valid    <= 1'b0;
      dout_prevalid <= 1'b0;
      if (coef_wr_ok)
        coef[CIDX_W'(coef_addr)] <= coef_wdata;

      if (state_clr) begin
        state     <= ST_IDLE;
        sec       <= '0;
        tap       <= '0;
        din_ready <= 1'b1;
        sat_flag  <= 1'b0;
        for (int unsigned k = 0; k < NUM_SEC; k++) begin
          x1[k] <= '0;
          x2[k] <= '0;
          y1[k] <= '0;
          y2[k] <= '0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              cur_x     <= DATA_W'($signed(din)) <<< IN_SHIFT;
              din_ready <= 1'b0;
              sec       <= '0;
              tap       <= '0;
              state     <= ST_MAC;
            end
          end
          ST_MAC: begin
            tap <= tap + 3'd1;
            if (tap == 3'(NUM_TAPS - 1))
              state <= ST_WB;
          end
          ST_WB: begin
            // Bypassed sections keep their history frozen
            if (!bypass_cur) begin
              x2[sec] <= x1[sec];
              x1[sec] <= cur_x;
              y2[sec] <= y1[sec];
              y1[sec] <= y_wb;
              if (mac_sat_c)
                sat_flag <= 1'b1;
            end
            cur_x <= y_wb;
            if (sec == '0)
              dout_prevalid <= 1'b1;
            if (sec == SEC_W'(NUM_SEC - 1)) begin
              dout       <= y_wb;
              dout_valid <= 1'b1;
              din_ready  <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              sec   <= sec + SEC_W'(1);
              tap   <= '0;
              state <= ST_MAC;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
